instr_fetch_responder: RTL and testbench

INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

---
 rtl/instr_fetch_responder_pkg.sv | 25 ++
 rtl/instr_fetch_responder_rsp_fifo2.sv | 77 +++++++
 rtl/instr_fetch_responder.sv | 92 +++++++++
 tb/tb_instr_fetch_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_responder_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_responder_pkg
// Shared types and constants for the instruction fetch responder.
//   fifo_state_t : occupancy of the 2-entry response FIFO (EMPTY/ONE/FULL)
//   rsp_t        : one queued response, instruction word plus fault flag
//   WORD_OFFSET  : byte-address bits below the word index
//   INSTR_W      : data width carried by rsp_t; the top's DATA matches it
// -----------------------------------------------------------------------------
package instr_fetch_responder_pkg;

    localparam int WORD_OFFSET = 2;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        logic               err;
    } rsp_t;

endpackage : instr_fetch_responder_pkg

// File: rtl/instr_fetch_responder_rsp_fifo2.sv
// -----------------------------------------------------------------------------
// rsp_fifo2
// Two-entry response FIFO whose occupancy is a three-state machine.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_entry: enqueue push_entry (ignored when FULL)
//   pop             : dequeue the head (ignored when EMPTY)
//   head            : oldest entry; only meaningful when state != EMPTY
//   state           : current occupancy
// -----------------------------------------------------------------------------
module rsp_fifo2
    import instr_fetch_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  rsp_t        push_entry,
    input  logic        pop,
    output rsp_t        head,
    output fifo_state_t state
);

    fifo_state_t next_state;
    rsp_t        slot0;
    rsp_t        slot1;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && (state != FULL);
    assign do_pop  = pop  && (state != EMPTY);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            EMPTY: if (do_push) next_state = ONE;
            ONE: begin
                if (do_push && !do_pop)      next_state = FULL;
                else if (do_pop && !do_push) next_state = EMPTY;
            end
            FULL:    if (do_pop) next_state = ONE;
            default: next_state = EMPTY;
        endcase
    end

    // NOTE: the entry slots have no reset; the state register alone decides
    // whether they hold anything, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (do_pop) begin
            if (state == FULL) begin
                slot0 <= slot1;            // FULL cannot push, just shift
            end else if (do_push) begin
                slot0 <= push_entry;       // ONE with push+pop: replace head
            end
        end else if (do_push) begin
            if (state == EMPTY) begin
                slot0 <= push_entry;
            end else begin
                slot1 <= push_entry;
            end
        end
    end

    assign head = slot0;

endmodule : rsp_fifo2

// File: rtl/instr_fetch_responder.sv
// -----------------------------------------------------------------------------
// instr_fetch_responder
// Instruction store with a valid/ready fetch port and a 1-cycle-latency,
// 2-deep buffered response port. Misaligned or out-of-range fetches return
// err=1 with zero data and flow through in order with the rest.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr   : fetch request (byte address)
//   rsp_valid/rsp_ready            : response handshake
//   rsp_data/rsp_err               : head response word and fault flag
//   wr_en/wr_addr/wr_data          : store load port (bad addresses ignored)
// -----------------------------------------------------------------------------
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int ADDRESS = 32,
    parameter int DATA    = 32,
    parameter int DEPTH   = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDRESS-1:0] req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA-1:0]    rsp_data,
    output logic               rsp_err,
    input  logic               wr_en,
    input  logic [ADDRESS-1:0] wr_addr,
    input  logic [DATA-1:0]    wr_data
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = WORD_OFFSET + IDX_W;   // first bit beyond the store

    logic [DATA-1:0]  mem [DEPTH];

    logic             req_fault;
    logic [IDX_W-1:0] req_idx;
    logic             wr_fault;
    logic [IDX_W-1:0] wr_idx;
    logic             push;
    logic             pop;
    rsp_t             push_entry;
    rsp_t             head;
    fifo_state_t      state;

    // A word index >= DEPTH is exactly "some address bit above the index set".
    assign req_fault = (|req_addr[WORD_OFFSET-1:0]) | (|req_addr[ADDRESS-1:HI_LSB]);
    assign req_idx   = req_addr[HI_LSB-1:WORD_OFFSET];
    assign wr_fault  = (|wr_addr[WORD_OFFSET-1:0]) | (|wr_addr[ADDRESS-1:HI_LSB]);
    assign wr_idx    = wr_addr[HI_LSB-1:WORD_OFFSET];

    // Store contents survive reset so a reset processor can refetch its code.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_fault) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // The read is captured into the FIFO at the accepting edge; a write to the
    // same word on that edge lands afterwards, so the old word is returned.
    always_comb begin
        push_entry.data = '0;
        push_entry.err  = req_fault;
        if (!req_fault) begin
            push_entry.data = INSTR_W'(mem[req_idx]);
        end
    end

    assign push = req_valid && req_ready;
    assign pop  = rsp_valid && rsp_ready;

    rsp_fifo2 u_rsp_fifo2 (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .state      (state)
    );

    // rst gating keeps req_ready low throughout reset; state already reads
    // EMPTY asynchronously, so rsp_valid needs no extra gating.
    assign req_ready = !rst && (state != FULL);
    assign rsp_valid = (state != EMPTY);
    assign rsp_data  = rsp_valid ? DATA'(head.data) : '0;
    assign rsp_err   = rsp_valid && head.err;

endmodule : instr_fetch_responder

// File: tb/tb_instr_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_responder
// Directed bench for instr_fetch_responder. Inputs change and outputs are
// sampled just after the falling edge, half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_responder;

    localparam int ADDRESS = 32;
    localparam int DATA    = 32;
    localparam int DEPTH   = 256;

    localparam logic [31:0] W0     = 32'h0000_0013;
    localparam logic [31:0] W1     = 32'h0050_0093;
    localparam logic [31:0] W_NEW  = 32'hDEAD_BEEF;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [ADDRESS-1:0] req_addr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA-1:0]    rsp_data;
    logic               rsp_err;
    logic               wr_en;
    logic [ADDRESS-1:0] wr_addr;
    logic [DATA-1:0]    wr_data;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_responder #(
        .ADDRESS (ADDRESS),
        .DATA    (DATA),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        // ---------------- reset state ----------------
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data",  rsp_data,  0);
        check("rst_rsp_err",   rsp_err,   0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", req_ready, 1);

        // ---------------- store load, including ignored writes ----------------
        wr_en = 1'b1; wr_addr = 32'h0;   wr_data = W0;
        step();
        wr_addr = 32'h4;   wr_data = W1;
        step();
        wr_addr = 32'h1;   wr_data = 32'hFFFF_FFFF;   // misaligned
        step();
        wr_addr = 32'h400; wr_data = 32'hAAAA_AAAA;   // index 256 out of range
        step();
        wr_en = 1'b0;

        // ---------------- back-to-back fetch ----------------
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        check("b2b_valid0", rsp_valid, 1);
        check("b2b_data0",  rsp_data,  W0);
        check("b2b_err0",   rsp_err,   0);
        req_addr = 32'h4;
        step();
        check("b2b_valid1", rsp_valid, 1);
        check("b2b_data1",  rsp_data,  W1);
        check("b2b_err1",   rsp_err,   0);
        req_valid = 1'b0;
        step();
        check("b2b_drained", rsp_valid, 0);

        // ---------------- backpressure: 3 requests, 2 fit ----------------
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        check("bp_ready_one", req_ready, 1);
        check("bp_head_a",    rsp_data,  W0);
        req_addr = 32'h4;
        step();
        check("bp_ready_full", req_ready, 0);
        check("bp_head_b",     rsp_data,  W0);
        req_addr = 32'h0;                    // third request waits
        step();
        check("bp_still_full", req_ready, 0);
        check("bp_head_stable", rsp_data, W0);
        rsp_ready = 1'b1;                    // pop; third must not enter yet
        step();
        check("bp_after_pop_ready", req_ready, 1);
        check("bp_second_word",     rsp_data,  W1);
        step();                              // third accepted alongside pop
        check("bp_third_valid", rsp_valid, 1);
        check("bp_third_word",  rsp_data,  W0);
        req_valid = 1'b0;
        step();
        check("bp_drained", rsp_valid, 0);

        // ---------------- faults ----------------
        req_valid = 1'b1; req_addr = 32'h2;
        step();
        check("flt_mis_valid", rsp_valid, 1);
        check("flt_mis_err",   rsp_err,   1);
        check("flt_mis_data",  rsp_data,  0);
        req_addr = 32'h400;
        step();
        check("flt_oor_err",  rsp_err,  1);
        check("flt_oor_data", rsp_data, 0);
        req_addr = 32'h4;
        step();
        check("flt_next_err",  rsp_err,  0);
        check("flt_next_data", rsp_data, W1);
        req_valid = 1'b0;
        step();
        check("flt_drained", rsp_valid, 0);

        // ---------------- push+pop in ONE for 10 edges ----------------
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        for (int i = 0; i < 10; i++) begin
            check("pp_valid", rsp_valid, 1);
            check("pp_ready", req_ready, 1);
            check("pp_word",  rsp_data,  (i % 2 == 0) ? W0 : W1);
            rsp_ready = 1'b1;
            req_addr  = ((i + 1) % 2 == 1) ? 32'h4 : 32'h0;
            step();
        end
        check("pp_last_word", rsp_data, W0);
        req_valid = 1'b0;
        step();
        check("pp_drained", rsp_valid, 0);

        // ---------------- reset with two entries queued ----------------
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_addr = 32'h4;
        step();
        check("mr_full_before", req_ready, 0);
        req_valid = 1'b0;
        rst = 1'b1;                          // mid-cycle, no clock edge yet
        #1;
        check("mr_valid_async", rsp_valid, 0);
        check("mr_data_async",  rsp_data,  0);
        check("mr_ready_async", req_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("mr_no_stale", rsp_valid, 0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        check("mr_refetch_data", rsp_data, W0);
        check("mr_refetch_err",  rsp_err,  0);
        req_valid = 1'b0;
        step();
        check("mr_drained", rsp_valid, 0);

        // ---------------- same-edge write and read ----------------
        wr_en = 1'b1; wr_addr = 32'h0; wr_data = W_NEW;
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        check("rw_old_word", rsp_data, W0);
        wr_en = 1'b0;
        step();
        check("rw_new_word", rsp_data, W_NEW);
        req_valid = 1'b0;
        step();
        check("rw_drained", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instr_fetch_responder
